// File: rtl/lcd_bus_sched.sv
// HD44780 character-LCD bus scheduler: two byte-write requesters, round-robin with lock,
// power-up delay and setup / EN pulse / hold / execution-wait timing on one down-counter.
module lcd_bus_sched #(
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC      = 3,
  parameter int unsigned EN_HIGH_CYC    = 12,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned WAIT_SHORT_CYC = 2000,
  parameter int unsigned WAIT_LONG_CYC  = 82000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  input  logic       r0_rs,
  input  logic [7:0] r0_data,
  input  logic       r0_lock,
  output logic       r0_ready,
  input  logic       r1_valid,
  input  logic       r1_rs,
  input  logic [7:0] r1_data,
  input  logic       r1_lock,
  output logic       r1_ready,
  output logic       busy,
  output logic       done,
  output logic       rs,
  output logic       en,
  output logic       rw,
  output logic [7:0] lcd_data
);

  localparam logic [2:0] S_PWRUP = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_PULSE = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;

  localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_SHORT = CNT_W'(WAIT_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(WAIT_LONG_CYC - 1);

  logic [2:0]       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             rs_nx, en_nx, done_nx, busy_nx;
  logic [7:0]       data_nx;
  logic             last_grant, last_nx;
  logic             lock_v, lock_v_nx, lock_own, lock_own_nx;
  logic             grant0_c, grant1_c, cnt_zero_c, long_cmd_c;

  assign rw         = 1'b0;
  assign cnt_zero_c = (cnt == '0);
  // Clear display / return home need the long execution wait.
  assign long_cmd_c = !rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03));

  // Grant selection: lock owner first, otherwise round-robin away from last_grant.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (lock_v) begin
      grant0_c = !lock_own;
      grant1_c = lock_own;
    end else if (r0_valid && r1_valid) begin
      grant0_c = last_grant;
      grant1_c = !last_grant;
    end else begin
      grant0_c = r0_valid;
      grant1_c = r1_valid;
    end
  end

  assign r0_ready = (state == S_IDLE) && grant0_c && r0_valid;
  assign r1_ready = (state == S_IDLE) && grant1_c && r1_valid;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    rs_nx       = rs;
    data_nx     = lcd_data;
    last_nx     = last_grant;
    lock_v_nx   = lock_v;
    lock_own_nx = lock_own;
    case (state)
      S_PWRUP: begin
        if (cnt_zero_c) state_nx = S_IDLE;
        else            cnt_nx   = cnt - CNT_W'(1);
      end
      S_IDLE: begin
        if (r0_ready || r1_ready) begin
          state_nx    = S_SETUP;
          cnt_nx      = LD_SETUP;
          rs_nx       = r1_ready ? r1_rs   : r0_rs;
          data_nx     = r1_ready ? r1_data : r0_data;
          last_nx     = r1_ready;
          lock_v_nx   = r1_ready ? r1_lock : r0_lock;
          lock_own_nx = r1_ready;
        end
      end
      S_SETUP: begin
        if (cnt_zero_c) begin
          state_nx = S_PULSE;
          cnt_nx   = LD_PULSE;
        end else cnt_nx = cnt - CNT_W'(1);
      end
      S_PULSE: begin
        if (cnt_zero_c) begin
          state_nx = S_HOLD;
          cnt_nx   = LD_HOLD;
        end else cnt_nx = cnt - CNT_W'(1);
      end
      S_HOLD: begin
        if (cnt_zero_c) begin
          state_nx = S_WAIT;
          cnt_nx   = long_cmd_c ? LD_LONG : LD_SHORT;
        end else cnt_nx = cnt - CNT_W'(1);
      end
      S_WAIT: begin
        if (cnt_zero_c) state_nx = S_IDLE;
        else            cnt_nx   = cnt - CNT_W'(1);
      end
      default: begin
        state_nx = S_PWRUP;
        cnt_nx   = LD_PWRUP;
      end
    endcase
    // Registered outputs follow the state being entered.
    en_nx   = (state_nx == S_PULSE);
    done_nx = (state_nx == S_WAIT) && (cnt_nx == '0);
    busy_nx = (state_nx != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_PWRUP;
      cnt        <= LD_PWRUP;
      rs         <= 1'b0;
      lcd_data   <= 8'h00;
      en         <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b1;
      last_grant <= 1'b1;
      lock_v     <= 1'b0;
      lock_own   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rs         <= rs_nx;
      lcd_data   <= data_nx;
      en         <= en_nx;
      done       <= done_nx;
      busy       <= busy_nx;
      last_grant <= last_nx;
      lock_v     <= lock_v_nx;
      lock_own   <= lock_own_nx;
    end
  end

endmodule

// File: tb/tb_lcd_bus_sched.sv
// Bench for lcd_bus_sched: drivers queue issued bytes; a cycle-timestamp model of the bus
// protocol pops them on accept and checks grants, LCD pin timing, done and busy.
module tb_lcd_bus_sched;

  localparam int P_PWR = 50;
  localparam int P_S   = 2;
  localparam int P_E   = 4;
  localparam int P_H   = 2;
  localparam int P_WS  = 20;
  localparam int P_WL  = 100;

  typedef struct packed {
    logic       lk;
    logic       rs;
    logic [7:0] d;
  } byte_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic r0_valid = 1'b0, r0_rs = 1'b0, r0_lock = 1'b0, r0_ready;
  logic r1_valid = 1'b0, r1_rs = 1'b0, r1_lock = 1'b0, r1_ready;
  logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
  logic busy, done, rs, en, rw;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_bus_sched #(
    .POWERUP_CYC(P_PWR), .SETUP_CYC(P_S), .EN_HIGH_CYC(P_E), .HOLD_CYC(P_H),
    .WAIT_SHORT_CYC(P_WS), .WAIT_LONG_CYC(P_WL), .CNT_W(20)
  ) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_rs(r0_rs), .r0_data(r0_data), .r0_lock(r0_lock), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_rs(r1_rs), .r1_data(r1_data), .r1_lock(r1_lock), .r1_ready(r1_ready),
    .busy(busy), .done(done), .rs(rs), .en(en), .rw(rw), .lcd_data(lcd_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int c = -1;
  byte_t q0[$], q1[$];
  int grant_log[$], acc_log[$];

  // Reference state: bus free from next_free; current byte accepted at cur_t.
  bit   lock_v_m, lock_own_m, last_m;
  int   next_free, cur_t, cur_w;
  logic cur_rs;
  logic [7:0] cur_d;
  byte_t e_m;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, c, act, exp);
    end
  endtask

  function automatic int wait_of(input logic r, input logic [7:0] d);
    return (!r && d >= 8'h01 && d <= 8'h03) ? P_WL : P_WS;
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    bit g0, g1;
    if (!rst) begin
      chk("rst_en", int'(en), 0);
      chk("rst_busy", int'(busy), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_rs_data", int'({rs, lcd_data}), 0);
      chk("rst_ready", int'({r0_ready, r1_ready}), 0);
      c = -1;
      lock_v_m = 0; lock_own_m = 0; last_m = 1;
      next_free = P_PWR;
      cur_t = -1000; cur_w = 0; cur_rs = 0; cur_d = 8'h00;
    end else begin
      c++;
      chk("busy", int'(busy), int'(c < next_free));
      chk("rw", int'(rw), 0);
      chk("en", int'(en), int'(c >= cur_t + 1 + P_S && c <= cur_t + P_S + P_E));
      chk("done", int'(done), int'(c == cur_t + P_S + P_E + P_H + cur_w));
      chk("rs", int'(rs), int'(cur_rs));
      chk("lcd_data", int'(lcd_data), int'(cur_d));
      g0 = 0; g1 = 0;
      if (c >= next_free) begin
        if (lock_v_m) begin
          g0 = !lock_own_m && r0_valid;
          g1 = lock_own_m && r1_valid;
        end else if (r0_valid && r1_valid) begin
          g0 = last_m;
          g1 = !last_m;
        end else begin
          g0 = r0_valid;
          g1 = r1_valid;
        end
      end
      chk("r0_ready", int'(r0_ready), int'(g0));
      chk("r1_ready", int'(r1_ready), int'(g1));
      if (g0 || g1) begin
        if ((g1 ? q1.size() : q0.size()) == 0) begin
          chk("queue_empty", 0, 1);
        end else begin
          e_m = g1 ? q1.pop_front() : q0.pop_front();
          cur_rs = e_m.rs; cur_d = e_m.d; cur_t = c;
          cur_w = wait_of(e_m.rs, e_m.d);
          next_free = c + P_S + P_E + P_H + cur_w + 1;
          last_m = g1; lock_v_m = e_m.lk; lock_own_m = g1;
          grant_log.push_back(int'(g1));
          acc_log.push_back(c);
        end
      end
    end
  end

  // Issue one byte from requester n; returns at posedge+1 after the accept.
  task automatic send(input int n, input logic rsv, input logic [7:0] d, input logic lk);
    bit ok;
    byte_t b;
    ok = 0;
    b = {lk, rsv, d};
    if (n == 0) begin
      q0.push_back(b); r0_rs = rsv; r0_data = d; r0_lock = lk; r0_valid = 1;
    end else begin
      q1.push_back(b); r1_rs = rsv; r1_data = d; r1_lock = lk; r1_valid = 1;
    end
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if ((n == 0) ? r0_ready : r1_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 0, 1);
      if (n == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
    @(posedge clk); #1;
    if (n == 0) r0_valid = 0; else r1_valid = 0;
  endtask

  task automatic stream(input int n, input int cnt, input int maxgap, input bit allow_lock);
    int gap;
    logic rsv, lk;
    logic [7:0] dv;
    for (int i = 0; i < cnt; i++) begin
      gap = $urandom_range(0, maxgap);
      if ($urandom % 6 == 0) begin
        rsv = 1'b0; dv = 8'($urandom_range(1, 3));
      end else begin
        rsv = 1'($urandom); dv = 8'($urandom);
      end
      lk = allow_lock && (i < cnt - 1) && ($urandom % 4 == 0);
      repeat (gap) @(posedge clk);
      if (gap > 0) #1;
      send(n, rsv, dv, lk);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy && !r0_valid && !r1_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired cyc=%0d", c);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit seen;
    // Power-up with both requesters valid from cycle 0: r0 first at 50, then r1 data 0x32.
    fork
      send(0, 1'b0, 8'h38, 1'b0);
      send(1, 1'b1, 8'h32, 1'b0);
      begin repeat (2) @(posedge clk); #1 rst = 1; end
    join
    wait_idle();
    chk("pwrup_first_acc", acc_log[0], P_PWR);
    chk("pwrup_order0", grant_log[0], 0);
    chk("pwrup_order1", grant_log[1], 1);

    // Clear command then display-on command.
    send(0, 1'b0, 8'h01, 1'b0);
    wait_idle();
    send(0, 1'b0, 8'h0C, 1'b0);
    wait_idle();

    // Contention without lock.
    base = grant_log.size();
    fork
      stream(0, 4, 0, 1'b0);
      stream(1, 4, 0, 1'b0);
    join
    wait_idle();
    chk("contention_count", grant_log.size() - base, 8);
    for (int i = base + 1; i < grant_log.size(); i++)
      chk("contention_alternate", int'(grant_log[i] != grant_log[i-1]), 1);

    // Locked four-byte sequence from r0 while r1 waits.
    base = grant_log.size();
    fork
      begin
        send(0, 1'b0, 8'h80, 1'b1);
        send(0, 1'b1, 8'h54, 1'b1);
        send(0, 1'b1, 8'h3D, 1'b1);
        send(0, 1'b1, 8'h32, 1'b0);
      end
      begin @(posedge clk); #1 send(1, 1'b1, 8'h43, 1'b0); end
    join
    wait_idle();
    chk("lock_count", grant_log.size() - base, 5);
    for (int i = 0; i < 5; i++)
      chk("lock_order", grant_log[base + i], (i == 4) ? 1 : 0);

    // Randomised traffic with gaps and occasional locks.
    fork
      stream(0, 15, 25, 1'b1);
      stream(1, 15, 25, 1'b1);
    join
    wait_idle();

    // Reset while EN is high, after a locked byte from r0.
    send(0, 1'b0, 8'h06, 1'b1);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (en) begin
        seen = 1;
        break;
      end
    end
    chk("en_seen", int'(seen), 1);
    @(posedge clk); #2 rst = 0;
    #1;
    chk("async_rst_en", int'(en), 0);
    chk("async_rst_busy", int'(busy), 1);
    repeat (3) @(posedge clk);
    #2 rst = 1;
    @(posedge clk); #1;
    base = grant_log.size();
    send(1, 1'b1, 8'h41, 1'b0);
    wait_idle();
    chk("post_rst_grant_count", grant_log.size() - base, 1);
    if (grant_log.size() > base) begin
      chk("post_rst_acc_cyc", acc_log[base], P_PWR);
      chk("post_rst_lock_cleared", grant_log[base], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
